// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on an accepted start; the result appears WIDTH cycles later with a done pulse.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one bit processed per clock; completes when count reaches WIDTH-1
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int PW = WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [PW-1:0]    partial;
   logic             carry;
   logic [CW-1:0]    count;

   logic ha1_s, ha1_c, ha2_c, s, co;

   // Full-adder cell built from two half adders and an OR.
   always_comb begin
      ha1_s = op_a[0] ^ op_b[0];
      ha1_c = op_a[0] & op_b[0];
      s     = ha1_s ^ carry;
      ha2_c = ha1_s & carry;
      co    = ha1_c | ha2_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_a     <= '0;
         op_b     <= '0;
         partial  <= '0;
         carry    <= 1'b0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= sub;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               // The lowest partial bit would only ever be shifted out, so it is not stored.
               partial <= PW'({s, partial} >> 1);
               op_a    <= op_a >> 1;
               op_b    <= op_b >> 1;
               carry   <= co;
               count   <= count + CW'(1);
               if (count == LAST) begin
                  sum      <= {s, partial};
                  cout     <= co;
                  overflow <= carry ^ co;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=8): hand-computed results, latency, handshake and reset behaviour.
module tb_serial_add_sub;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       sub;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;

   serial_add_sub #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Drive a start for one cycle; returns at the negedge just after the accepting edge.
   task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
      @(negedge clk);
      a     = ta;
      b     = tb;
      sub   = ts;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      sub   = 1'b0;
   endtask

   // Waits (bounded) until done is seen at a negedge; counts cycles and busy samples.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = 0;
      if (busy) busy_cnt++;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (busy) busy_cnt++;
      end
   endtask

   task automatic check_result(input string name, input logic [7:0] es, input logic ec, input logic eo);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done: got %b expected 1", name, done);
      end
      n_checks++;
      if (sum !== es) begin
         n_fail++;
         $display("FAIL %s sum: got %h expected %h", name, sum, es);
      end
      n_checks++;
      if (cout !== ec) begin
         n_fail++;
         $display("FAIL %s cout: got %b expected %b", name, cout, ec);
      end
      n_checks++;
      if (overflow !== eo) begin
         n_fail++;
         $display("FAIL %s overflow: got %b expected %b", name, overflow, eo);
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, sum, cout, overflow} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                  busy, done, sum, cout, overflow);
      end
      rst = 1'b0;
   endtask

   task automatic test_add_carry();
      int lat, bc;
      launch(8'hC8, 8'h64, 1'b0);
      wait_done(lat, bc);
      n_checks++;
      if (lat != 8) begin
         n_fail++;
         $display("FAIL add_carry latency: got %0d expected 8", lat);
      end
      check_result("add_carry", 8'h2C, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL add_carry done_width: got %b expected 0", done);
      end
   endtask

   task automatic test_add_overflow();
      int lat, bc;
      launch(8'h64, 8'h32, 1'b0);
      wait_done(lat, bc);
      n_checks++;
      if (bc != 8) begin
         n_fail++;
         $display("FAIL add_ovf busy_cycles: got %0d expected 8", bc);
      end
      check_result("add_ovf", 8'h96, 1'b0, 1'b1);
   endtask

   task automatic test_sub_borrow();
      int lat, bc;
      launch(8'h05, 8'h07, 1'b1);
      wait_done(lat, bc);
      check_result("sub_borrow", 8'hFE, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      launch(8'h80, 8'h01, 1'b1);
      wait_done(lat, bc);
      check_result("sub_ovf", 8'h7F, 1'b1, 1'b1);
      // Start presented in the done cycle must be accepted on the next edge.
      a     = 8'hFF;
      b     = 8'hFF;
      sub   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b no_gap busy: got %b expected 1", busy);
      end
      wait_done(lat, bc);
      n_checks++;
      if (lat != 8) begin
         n_fail++;
         $display("FAIL b2b latency: got %0d expected 8", lat);
      end
      check_result("b2b", 8'hFE, 1'b1, 1'b0);
   endtask

   task automatic test_ignore_start();
      int lat, bc;
      launch(8'h0F, 8'h01, 1'b0);
      @(negedge clk);
      a     = 8'hAA;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (sum !== 8'hFE) begin
         n_fail++;
         $display("FAIL ignore sum_hold: got %h expected fe", sum);
      end
      wait_done(lat, bc);
      n_checks++;
      if (lat != 6) begin
         n_fail++;
         $display("FAIL ignore latency: got %0d expected 6", lat);
      end
      check_result("ignore", 8'h10, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore no_second_op: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_reset_midrun();
      int lat, bc;
      int seen_done;
      launch(8'h33, 8'h11, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({busy, done, sum, cout, overflow} !== 12'h000) begin
         n_fail++;
         $display("FAIL midrun_reset outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                  busy, done, sum, cout, overflow);
      end
      seen_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      n_checks++;
      if (seen_done != 0) begin
         n_fail++;
         $display("FAIL midrun_reset stray_done: got %0d pulses expected 0", seen_done);
      end
      // Reset and start on the same edge: reset wins.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h01;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_start busy: got %b expected 0", busy);
      end
      launch(8'h01, 8'h01, 1'b0);
      wait_done(lat, bc);
      check_result("post_reset", 8'h02, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_add_overflow();
      test_sub_borrow();
      test_back_to_back();
      test_ignore_start();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
